// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register scoreboard for load-use stall and EX forwarding select
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MEM_LAT = 1,
    parameter int PW      = 2,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [AW-1:0] id_dest,
    input  logic          id_wb_en,
    input  logic          id_is_load,
    output logic          stall,
    output logic [PW-1:0] fwd_rs_sel,
    output logic [PW-1:0] fwd_rt_sel,
    output logic [CW-1:0] stall_count
);

    // Pipeline positions: EX=1, MEM stages 2..1+MEM_LAT, WB=2+MEM_LAT.
    localparam logic [PW-1:0] POS_WB       = PW'(2 + MEM_LAT);
    localparam logic [PW-1:0] POS_LAST_MEM = PW'(1 + MEM_LAT);

    logic [PW-1:0]   pos_q [NREG];
    logic [PW-1:0]   pos_d [NREG];
    logic [NREG-1:0] ld_q;
    logic [NREG-1:0] ld_d;
    logic [PW-1:0]   fwd_rs_sel_q, fwd_rs_sel_d;
    logic [PW-1:0]   fwd_rt_sel_q, fwd_rt_sel_d;
    logic [CW-1:0]   stall_count_q, stall_count_d;

    logic [PW-1:0] rs_pos, rt_pos;
    logic          rs_ld, rt_ld;
    logic          rs_hazard, rt_hazard;
    logic [PW-1:0] rs_sel, rt_sel;
    logic          accept;
    logic          dest_in_range;

    // Fetch the scoreboard entry of each source; indices beyond NREG read as untracked.
    always_comb begin
        rs_pos = '0;
        rs_ld  = 1'b0;
        rt_pos = '0;
        rt_ld  = 1'b0;
        if (32'(id_rs) < NREG) begin
            rs_pos = pos_q[id_rs];
            rs_ld  = ld_q[id_rs];
        end
        if (32'(id_rt) < NREG) begin
            rt_pos = pos_q[id_rt];
            rt_ld  = ld_q[id_rt];
        end
    end

    // Hazard and select per source: the producer advances one stage by the consumer's EX cycle.
    // A producer already in WB is picked up by the write-first register file, so select 0.
    always_comb begin
        rs_hazard = 1'b0;
        rs_sel    = '0;
        rt_hazard = 1'b0;
        rt_sel    = '0;
        if (id_rs_used && id_rs != '0 && rs_pos != '0) begin
            if (rs_ld && rs_pos < POS_LAST_MEM) begin
                rs_hazard = 1'b1;
            end else if (rs_pos != POS_WB) begin
                rs_sel = rs_pos + 1'b1;
            end
        end
        if (id_rt_used && id_rt != '0 && rt_pos != '0) begin
            if (rt_ld && rt_pos < POS_LAST_MEM) begin
                rt_hazard = 1'b1;
            end else if (rt_pos != POS_WB) begin
                rt_sel = rt_pos + 1'b1;
            end
        end
    end

    assign stall         = id_valid & (rs_hazard | rt_hazard);
    assign accept        = id_valid & ~stall & ~hold;
    assign dest_in_range = (32'(id_dest) < NREG) && (id_dest != '0);

    // Advance every in-flight writer, retire from WB, then let a newly accepted writer claim its register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pos_d[r] = pos_q[r];
            ld_d[r]  = ld_q[r];
        end
        if (!hold) begin
            for (int r = 0; r < NREG; r++) begin
                if (pos_q[r] == POS_WB) begin
                    pos_d[r] = '0;
                end else if (pos_q[r] != '0) begin
                    pos_d[r] = pos_q[r] + 1'b1;
                end
            end
            if (accept && id_wb_en && dest_in_range) begin
                pos_d[id_dest] = PW'(1);
                ld_d[id_dest]  = id_is_load;
            end
        end
        pos_d[0] = '0;
        ld_d[0]  = 1'b0;
    end

    // Forwarding selects follow the instruction into EX; bubbles get select 0; hold freezes them.
    always_comb begin
        fwd_rs_sel_d = fwd_rs_sel_q;
        fwd_rt_sel_d = fwd_rt_sel_q;
        if (!hold) begin
            fwd_rs_sel_d = accept ? rs_sel : '0;
            fwd_rt_sel_d = accept ? rt_sel : '0;
        end
    end

    // Saturating count of cycles spent in load-use stall while the pipeline is not held.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !hold && stall_count_q != '1) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                pos_q[r] <= '0;
            end
            ld_q          <= '0;
            fwd_rs_sel_q  <= '0;
            fwd_rt_sel_q  <= '0;
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pos_q[r] <= pos_d[r];
            end
            ld_q          <= ld_d;
            fwd_rs_sel_q  <= fwd_rs_sel_d;
            fwd_rt_sel_q  <= fwd_rt_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_rs_sel  = fwd_rs_sel_q;
    assign fwd_rt_sel  = fwd_rt_sel_q;
    assign stall_count = stall_count_q;

endmodule
